// File: rtl/wb_resp_sequencer.sv
// Wishbone slave answering core reads from two bench-filled FIFOs (instruction, load data),
// capturing stores, with programmable wait states and a stall timeout that raises err.
module wb_resp_sequencer #(
  parameter int INST_DEPTH  = 8,
  parameter int DATA_DEPTH  = 4,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst_data,
  output logic        inst_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        i_is_fetch,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        wr_valid,
  output logic [31:0] wr_adr,
  output logic [31:0] wr_dat,
  output logic [3:0]  wr_sel,
  output logic [15:0] fetch_cnt,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt
);

  localparam int IAW     = $clog2(INST_DEPTH);
  localparam int DAW     = $clog2(DATA_DEPTH);
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, SERVE, ERR} state_t;

  state_t               state_reg;
  logic [3:0]           wait_cnt_reg;
  logic [STALL_W-1:0]   stall_cnt_reg;
  logic [31:0]          adr_reg;
  logic [31:0]          dat_reg;
  logic [3:0]           sel_reg;
  logic                 we_reg;
  logic                 fetch_reg;

  logic [31:0]          inst_mem [INST_DEPTH];
  logic [IAW-1:0]       inst_wr_ptr_reg, inst_rd_ptr_reg;
  logic [IAW:0]         inst_cnt_reg;
  logic [31:0]          ld_mem [DATA_DEPTH];
  logic [DAW-1:0]       ld_wr_ptr_reg, ld_rd_ptr_reg;
  logic [DAW:0]         ld_cnt_reg;

  logic inst_full, inst_empty, ld_full, ld_empty;
  logic inst_push, inst_pop, ld_push, ld_pop;
  logic req, serve_read;

  assign inst_full  = (inst_cnt_reg == (IAW+1)'(INST_DEPTH));
  assign inst_empty = (inst_cnt_reg == '0);
  assign ld_full    = (ld_cnt_reg == (DAW+1)'(DATA_DEPTH));
  assign ld_empty   = (ld_cnt_reg == '0);
  assign inst_ready = ~inst_full;
  assign ld_ready   = ~ld_full;

  // Full is judged on the registered count, so a push while full is dropped even if a pop coincides.
  assign inst_push  = inst_valid & ~inst_full;
  assign ld_push    = ld_valid & ~ld_full;

  assign req        = i_wb_cyc & i_wb_stb;
  assign serve_read = (state_reg == SERVE) && req && !we_reg;
  assign inst_pop   = serve_read && fetch_reg && !inst_empty;
  assign ld_pop     = serve_read && !fetch_reg && !ld_empty;

  always_ff @(posedge clk) begin
    if (inst_push) inst_mem[inst_wr_ptr_reg] <= inst_data;
    if (ld_push)   ld_mem[ld_wr_ptr_reg]     <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_wr_ptr_reg <= '0;
      inst_rd_ptr_reg <= '0;
      inst_cnt_reg    <= '0;
      ld_wr_ptr_reg   <= '0;
      ld_rd_ptr_reg   <= '0;
      ld_cnt_reg      <= '0;
    end else begin
      if (inst_push) inst_wr_ptr_reg <= inst_wr_ptr_reg + IAW'(1);
      if (inst_pop)  inst_rd_ptr_reg <= inst_rd_ptr_reg + IAW'(1);
      case ({inst_push, inst_pop})
        2'b10:   inst_cnt_reg <= inst_cnt_reg + (IAW+1)'(1);
        2'b01:   inst_cnt_reg <= inst_cnt_reg - (IAW+1)'(1);
        default: inst_cnt_reg <= inst_cnt_reg;
      endcase
      if (ld_push) ld_wr_ptr_reg <= ld_wr_ptr_reg + DAW'(1);
      if (ld_pop)  ld_rd_ptr_reg <= ld_rd_ptr_reg + DAW'(1);
      case ({ld_push, ld_pop})
        2'b10:   ld_cnt_reg <= ld_cnt_reg + (DAW+1)'(1);
        2'b01:   ld_cnt_reg <= ld_cnt_reg - (DAW+1)'(1);
        default: ld_cnt_reg <= ld_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      sel_reg       <= '0;
      we_reg        <= 1'b0;
      fetch_reg     <= 1'b0;
      o_wb_dat      <= '0;
      o_wb_ack      <= 1'b0;
      o_wb_err      <= 1'b0;
      wr_valid      <= 1'b0;
      wr_adr        <= '0;
      wr_dat        <= '0;
      wr_sel        <= '0;
      fetch_cnt     <= '0;
      load_cnt      <= '0;
      store_cnt     <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      wr_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            adr_reg       <= i_wb_adr;
            dat_reg       <= i_wb_dat;
            sel_reg       <= i_wb_sel;
            we_reg        <= i_wb_we;
            fetch_reg     <= i_is_fetch;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            state_reg     <= (WAIT_STATES > 0) ? WAIT : SERVE;
          end
        end
        WAIT: begin
          if (!req)                         state_reg    <= IDLE;
          else if (wait_cnt_reg == WAIT_LAST) state_reg  <= SERVE;
          else                              wait_cnt_reg <= wait_cnt_reg + 4'd1;
        end
        SERVE: begin
          if (!req) begin
            state_reg <= IDLE;
          end else if (we_reg) begin
            o_wb_ack  <= 1'b1;
            wr_valid  <= 1'b1;
            wr_adr    <= adr_reg;
            wr_dat    <= dat_reg;
            wr_sel    <= sel_reg;
            store_cnt <= store_cnt + 16'd1;
            state_reg <= IDLE;
          end else if (inst_pop) begin
            o_wb_dat  <= inst_mem[inst_rd_ptr_reg];
            o_wb_ack  <= 1'b1;
            fetch_cnt <= fetch_cnt + 16'd1;
            state_reg <= IDLE;
          end else if (ld_pop) begin
            o_wb_dat  <= ld_mem[ld_rd_ptr_reg];
            o_wb_ack  <= 1'b1;
            load_cnt  <= load_cnt + 16'd1;
            state_reg <= IDLE;
          end else if (stall_cnt_reg == STALL_LAST) begin
            // err is raised on entry so it is high exactly for the ERR cycle
            o_wb_err  <= 1'b1;
            o_wb_dat  <= '0;
            state_reg <= ERR;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
          end
        end
        ERR:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_resp_sequencer.sv
// Directed bench: dut0 (no wait states, TIMEOUT=4) covers serving, stores, timeout and FIFO full;
// dut3 (3 wait states) covers latency and reset during WAIT.
module tb_wb_resp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, ld_valid;
  logic [31:0] inst_data, ld_data;
  logic        i_is_fetch, i_wb_we, i_wb_cyc, i_wb_stb;
  logic [31:0] i_wb_adr, i_wb_dat;
  logic [3:0]  i_wb_sel;

  logic        inst_ready_0, ld_ready_0, ack_0, err_0, wr_valid_0;
  logic [31:0] rdat_0, wr_adr_0, wr_dat_0;
  logic [3:0]  wr_sel_0;
  logic [15:0] fetch_cnt_0, load_cnt_0, store_cnt_0;

  logic        inst_ready_3, ld_ready_3, ack_3, err_3, wr_valid_3;
  logic [31:0] rdat_3, wr_adr_3, wr_dat_3;
  logic [3:0]  wr_sel_3;
  logic [15:0] fetch_cnt_3, load_cnt_3, store_cnt_3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_resp_sequencer #(.INST_DEPTH(8), .DATA_DEPTH(4), .WAIT_STATES(0), .TIMEOUT(4)) dut0 (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready_0),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_0),
    .i_is_fetch(i_is_fetch), .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_dat(i_wb_dat), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_dat(rdat_0), .o_wb_ack(ack_0), .o_wb_err(err_0),
    .wr_valid(wr_valid_0), .wr_adr(wr_adr_0), .wr_dat(wr_dat_0), .wr_sel(wr_sel_0),
    .fetch_cnt(fetch_cnt_0), .load_cnt(load_cnt_0), .store_cnt(store_cnt_0)
  );

  wb_resp_sequencer #(.INST_DEPTH(8), .DATA_DEPTH(4), .WAIT_STATES(3), .TIMEOUT(4)) dut3 (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready_3),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_3),
    .i_is_fetch(i_is_fetch), .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_dat(i_wb_dat), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_dat(rdat_3), .o_wb_ack(ack_3), .o_wb_err(err_3),
    .wr_valid(wr_valid_3), .wr_adr(wr_adr_3), .wr_dat(wr_dat_3), .wr_sel(wr_sel_3),
    .fetch_cnt(fetch_cnt_3), .load_cnt(load_cnt_3), .store_cnt(store_cnt_3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [31:0] w);
    inst_valid = 1'b1; inst_data = w;
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic push_ld(input logic [31:0] w);
    ld_valid = 1'b1; ld_data = w;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic bus_req(input logic we, input logic fetch, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    i_wb_we = we; i_is_fetch = fetch; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
  endtask

  task automatic bus_idle();
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  // Read on dut0: accept, ack one cycle later, then the pulse must drop.
  task automatic read0(input string tag, input logic fetch, input logic [31:0] adr,
                       input logic [31:0] exp);
    bus_req(1'b0, fetch, adr, 32'h0, 4'hF);
    tick();
    check_eq({tag, "_ack_early"}, 32'(ack_0), 32'd0);
    tick();
    check_eq({tag, "_ack"}, 32'(ack_0), 32'd1);
    check_eq({tag, "_dat"}, rdat_0, exp);
    bus_idle();
    tick();
    check_eq({tag, "_ack_pulse"}, 32'(ack_0), 32'd0);
  endtask

  // Fetch on dut0 against an empty inst FIFO: err in the 4th stall cycle only.
  task automatic timeout0(input string tag);
    bus_req(1'b0, 1'b1, 32'h0, 32'h0, 4'hF);
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq($sformatf("%s_err_c%0d", tag, i), 32'(err_0), 32'(i == 4));
      check_eq($sformatf("%s_ack_c%0d", tag, i), 32'(ack_0), 32'd0);
    end
    check_eq({tag, "_dat0"}, rdat_0, 32'h0);
    bus_idle();
    tick();
    check_eq({tag, "_err_pulse"}, 32'(err_0), 32'd0);
  endtask

  initial begin
    logic saw_ack, saw_err;
    rst = 1'b1;
    inst_valid = 1'b0; inst_data = '0; ld_valid = 1'b0; ld_data = '0;
    i_is_fetch = 1'b0; i_wb_adr = '0; i_wb_sel = '0; i_wb_dat = '0;
    bus_idle();
    tick(); tick();
    rst = 1'b0;

    check_eq("rst_inst_ready", 32'(inst_ready_0), 32'd1);
    check_eq("rst_ld_ready", 32'(ld_ready_0), 32'd1);
    check_eq("rst_ack", 32'(ack_0), 32'd0);
    check_eq("rst_err", 32'(err_0), 32'd0);
    check_eq("rst_dat", rdat_0, 32'h0);
    check_eq("rst_fetch_cnt", 32'(fetch_cnt_0), 32'd0);

    // single fetch
    push_inst(32'hE3A01005);
    read0("fetch1", 1'b1, 32'h0, 32'hE3A01005);
    check_eq("fetch1_cnt", 32'(fetch_cnt_0), 32'd1);

    // fetch / load / fetch: load must not disturb the inst FIFO
    push_inst(32'h11111111);
    push_inst(32'h22222222);
    push_ld(32'hDEADBEEF);
    read0("fetch2", 1'b1, 32'h4, 32'h11111111);
    read0("load1", 1'b0, 32'h200, 32'hDEADBEEF);
    check_eq("load1_cnt", 32'(load_cnt_0), 32'd1);
    read0("fetch3", 1'b1, 32'h8, 32'h22222222);
    check_eq("fetch3_cnt", 32'(fetch_cnt_0), 32'd3);

    // store capture
    bus_req(1'b1, 1'b0, 32'h100, 32'h12345678, 4'hF);
    tick();
    check_eq("store_ack_early", 32'(ack_0), 32'd0);
    tick();
    check_eq("store_ack", 32'(ack_0), 32'd1);
    check_eq("store_wr_valid", 32'(wr_valid_0), 32'd1);
    check_eq("store_wr_adr", wr_adr_0, 32'h100);
    check_eq("store_wr_dat", wr_dat_0, 32'h12345678);
    check_eq("store_wr_sel", 32'(wr_sel_0), 32'hF);
    check_eq("store_cnt", 32'(store_cnt_0), 32'd1);
    bus_idle();
    tick();
    check_eq("store_wr_valid_pulse", 32'(wr_valid_0), 32'd0);

    // stall timeout on empty inst FIFO
    timeout0("tmo1");
    check_eq("tmo1_fetch_cnt", 32'(fetch_cnt_0), 32'd3);

    // strobe dropped before ack: no pop, word still served later
    push_ld(32'h55555555);
    bus_req(1'b0, 1'b0, 32'h300, 32'h0, 4'hF);
    tick();
    bus_idle();
    tick();
    check_eq("abort_ack", 32'(ack_0), 32'd0);
    tick();
    check_eq("abort_ack2", 32'(ack_0), 32'd0);
    check_eq("abort_load_cnt", 32'(load_cnt_0), 32'd1);
    read0("load2", 1'b0, 32'h304, 32'h55555555);
    check_eq("load2_cnt", 32'(load_cnt_0), 32'd2);

    // fill inst FIFO; 9th push coincides with a pop and must be dropped
    for (int i = 0; i < 8; i++) push_inst(32'hA000_0000 + 32'(i));
    check_eq("full_inst_ready", 32'(inst_ready_0), 32'd0);
    bus_req(1'b0, 1'b1, 32'h0, 32'h0, 4'hF);
    tick();
    check_eq("full_inst_ready_hold", 32'(inst_ready_0), 32'd0);
    inst_valid = 1'b1; inst_data = 32'hBAD0BAD0;
    tick();
    inst_valid = 1'b0;
    check_eq("full_pop_ack", 32'(ack_0), 32'd1);
    check_eq("full_pop_dat", rdat_0, 32'hA0000000);
    check_eq("full_after_pop_ready", 32'(inst_ready_0), 32'd1);
    bus_idle();
    tick();
    for (int i = 1; i < 8; i++) read0($sformatf("drain%0d", i), 1'b1, 32'h0, 32'hA000_0000 + 32'(i));
    check_eq("drain_fetch_cnt", 32'(fetch_cnt_0), 32'd11);
    timeout0("tmo_dropped9");

    // dut3: accept -> ack latency of 4 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_inst(32'hCAFE0001);
    bus_req(1'b0, 1'b1, 32'h0, 32'h0, 4'hF);
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq($sformatf("ws3_ack_c%0d", i), 32'(ack_3), 32'd0);
    end
    tick();
    check_eq("ws3_ack", 32'(ack_3), 32'd1);
    check_eq("ws3_dat", rdat_3, 32'hCAFE0001);
    check_eq("ws3_fetch_cnt", 32'(fetch_cnt_3), 32'd1);
    bus_idle();
    tick();

    // dut3: reset while in WAIT abandons the request
    push_inst(32'hCAFE0002);
    bus_req(1'b0, 1'b1, 32'h0, 32'h0, 4'hF);
    tick();
    tick();
    rst = 1'b1;
    bus_idle();
    tick();
    rst = 1'b0;
    check_eq("rstw_ack", 32'(ack_3), 32'd0);
    check_eq("rstw_err", 32'(err_3), 32'd0);
    check_eq("rstw_inst_ready", 32'(inst_ready_3), 32'd1);
    check_eq("rstw_ld_ready", 32'(ld_ready_3), 32'd1);
    check_eq("rstw_fetch_cnt", 32'(fetch_cnt_3), 32'd0);
    check_eq("rstw_dat", rdat_3, 32'h0);
    tick();
    check_eq("rstw_ack_after", 32'(ack_3), 32'd0);

    // inst FIFO must be empty after reset: a fetch times out instead of acking
    saw_ack = 1'b0; saw_err = 1'b0;
    bus_req(1'b0, 1'b1, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 12 && !saw_err; i++) begin
      tick();
      if (ack_3) saw_ack = 1'b1;
      if (err_3) saw_err = 1'b1;
    end
    bus_idle();
    check_eq("rstw_empty_err", 32'(saw_err), 32'd1);
    check_eq("rstw_empty_ack", 32'(saw_ack), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
